bus_arbiter: RTL and testbench

Sequential arbiter and slave-select controller for the two-master / three-slave serial system bus. It grants the bus to one master, captures the 2-bit slave ID the granted master shifts out on its `tx_address` line, then drives the `bus_grant`/`slave_grant` codes consumed by the master-to-slave mux. It holds the connection until the master releases it or goes idle too long, and it sits between the master ports and the master mux.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_arb_select.sv | 42 ++++
 rtl/bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and encodings for the two-master / three-slave serial bus arbiter.
package bus_pkg;

    localparam int SLV_ID_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ADDR    = 2'b01,
        CONNECT = 2'b10,
        RELEASE = 2'b11
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M1   = 2'b01;
    localparam logic [1:0] GRANT_M2   = 2'b10;

    localparam logic [2:0] SLV_NONE = 3'b000;
    localparam logic [2:0] SLV1     = 3'b011;
    localparam logic [2:0] SLV2     = 3'b101;
    localparam logic [2:0] SLV3     = 3'b111;

endpackage

// File: rtl/bus_arb_select.sv
// Winner selection between the two masters; BUS_ARB_ROUND_ROBIN_EN adds a
// registered pointer that favours the master not granted most recently.
module bus_arb_select
    import bus_pkg::*;
(
`ifdef BUS_ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       grant_en,
`endif
    input  logic       m1_req,
    input  logic       m2_req,
    output logic [1:0] winner
);

    logic prio_m2;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // After granting master 1, master 2 wins the next tie, and vice versa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_m2 <= 1'b0;
        end else if (grant_en) begin
            prio_m2 <= (winner == GRANT_M1);
        end
    end
`else
    assign prio_m2 = 1'b0;
`endif

    always_comb begin
        winner = GRANT_NONE;
        if (m1_req && m2_req) begin
            winner = prio_m2 ? GRANT_M2 : GRANT_M1;
        end else if (m1_req) begin
            winner = GRANT_M1;
        end else if (m2_req) begin
            winner = GRANT_M2;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Bus arbiter and slave-select controller: grant, serial slave-ID capture, connect, release.
// Tie-break is fixed (master 1) unless BUS_ARB_ROUND_ROBIN_EN is defined.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       m1_request,
    input  logic       m2_request,
    input  logic       m1_master_valid,
    input  logic       m2_master_valid,
    input  logic       m1_tx_address,
    input  logic       m2_tx_address,
    output logic [1:0] bus_grant,
    output logic [2:0] slave_grant,
    output logic       busy,
    output logic       decode_err,
    output logic       timeout
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t              state;
    logic [1:0]          owner;
    logic [2:0]          slv_code;
    logic                first_bit;
    logic                bit_seen;
    logic [7:0]          idle_cnt;
    logic [7:0]          idle_cnt_inc;
    logic [1:0]          winner;
    logic                own_req;
    logic                own_valid;
    logic                own_tx;
    logic                timeout_hit;
    logic [SLV_ID_W-1:0] id_next;

    function automatic logic [2:0] slave_code(input logic [SLV_ID_W-1:0] id);
        case (id)
            2'b01:   slave_code = SLV1;
            2'b10:   slave_code = SLV2;
            2'b11:   slave_code = SLV3;
            default: slave_code = SLV_NONE;
        endcase
    endfunction

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic grant_en;
    assign grant_en = (state == IDLE) && (m1_request || m2_request);

    bus_arb_select u_select (
        .clk      (clk),
        .rst      (rst),
        .grant_en (grant_en),
        .m1_req   (m1_request),
        .m2_req   (m2_request),
        .winner   (winner)
    );
`else
    bus_arb_select u_select (
        .m1_req   (m1_request),
        .m2_req   (m2_request),
        .winner   (winner)
    );
`endif

    // Only the owning master's lines matter once granted.
    assign own_req   = (owner == GRANT_M2) ? m2_request      : m1_request;
    assign own_valid = (owner == GRANT_M2) ? m2_master_valid : m1_master_valid;
    assign own_tx    = (owner == GRANT_M2) ? m2_tx_address   : m1_tx_address;

    assign id_next      = {first_bit, own_tx};
    assign idle_cnt_inc = (idle_cnt >= TIMEOUT_C) ? idle_cnt : idle_cnt + 8'd1;
    assign timeout_hit  = !own_valid && (idle_cnt_inc >= TIMEOUT_C);

    // Grant outputs follow the state one edge later; pulses fire on the deciding edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= GRANT_NONE;
            slv_code    <= SLV_NONE;
            first_bit   <= 1'b0;
            bit_seen    <= 1'b0;
            idle_cnt    <= 8'd0;
            bus_grant   <= GRANT_NONE;
            slave_grant <= SLV_NONE;
            busy        <= 1'b0;
            decode_err  <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            decode_err  <= 1'b0;
            timeout     <= 1'b0;
            bus_grant   <= (state == ADDR || state == CONNECT) ? owner : GRANT_NONE;
            slave_grant <= (state == CONNECT) ? slv_code : SLV_NONE;
            busy        <= (state != IDLE);

            case (state)
                IDLE: begin
                    if (winner != GRANT_NONE) begin
                        owner     <= winner;
                        first_bit <= 1'b0;
                        bit_seen  <= 1'b0;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (!own_req) begin
                        state <= RELEASE;
                    end else if (own_valid) begin
                        if (bit_seen) begin
                            if (id_next == '0) begin
                                decode_err <= 1'b1;
                                state      <= RELEASE;
                            end else begin
                                slv_code <= slave_code(id_next);
                                idle_cnt <= 8'd0;
                                state    <= CONNECT;
                            end
                        end else begin
                            first_bit <= own_tx;
                            bit_seen  <= 1'b1;
                        end
                    end
                end
                CONNECT: begin
                    // Timeout wins over a simultaneous request drop so the pulse is not lost.
                    if (timeout_hit) begin
                        timeout  <= 1'b1;
                        idle_cnt <= idle_cnt_inc;
                        state    <= RELEASE;
                    end else if (!own_req) begin
                        state <= RELEASE;
                    end else begin
                        idle_cnt <= own_valid ? 8'd0 : idle_cnt_inc;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected outputs, a monitor pops and compares.
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       m1_request, m2_request;
    logic       m1_master_valid, m2_master_valid;
    logic       m1_tx_address, m2_tx_address;
    logic [1:0] bus_grant;
    logic [2:0] slave_grant;
    logic       busy, decode_err, timeout;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam logic [1:0] WIN2 = 2'b10;
`else
    localparam logic [1:0] WIN2 = 2'b01;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      nm_q[$];
    event       sample_ev;

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .m1_request      (m1_request),
        .m2_request      (m2_request),
        .m1_master_valid (m1_master_valid),
        .m2_master_valid (m2_master_valid),
        .m1_tx_address   (m1_tx_address),
        .m2_tx_address   (m2_tx_address),
        .bus_grant       (bus_grant),
        .slave_grant     (slave_grant),
        .busy            (busy),
        .decode_err      (decode_err),
        .timeout         (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare after every rising edge, or on demand for asynchronous events.
    initial begin
        logic [7:0] exp_v;
        logic [7:0] got_v;
        string      nm;
        forever begin
            @(posedge clk or sample_ev);
            #2;
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                nm    = nm_q.pop_front();
                got_v = {bus_grant, slave_grant, busy, decode_err, timeout};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got bg=%b sg=%b busy=%b de=%b to=%b, expected bg=%b sg=%b busy=%b de=%b to=%b",
                             nm, got_v[7:6], got_v[5:3], got_v[2], got_v[1], got_v[0],
                             exp_v[7:6], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    // Drive one vector for the next rising edge and queue the outputs expected after it.
    task automatic vec(input string nm,
                       input logic r1, input logic r2, input logic v1, input logic v2,
                       input logic t1, input logic t2,
                       input logic [1:0] bg, input logic [2:0] sg,
                       input logic bz, input logic de, input logic to);
        @(negedge clk);
        m1_request      = r1;
        m2_request      = r2;
        m1_master_valid = v1;
        m2_master_valid = v2;
        m1_tx_address   = t1;
        m2_tx_address   = t2;
        exp_q.push_back({bg, sg, bz, de, to});
        nm_q.push_back(nm);
    endtask

    task automatic drive_idle();
        m1_request      = 1'b0;
        m2_request      = 1'b0;
        m1_master_valid = 1'b0;
        m2_master_valid = 1'b0;
        m1_tx_address   = 1'b0;
        m2_tx_address   = 1'b0;
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        #1;
        exp_q.push_back(8'h00);
        nm_q.push_back("reset");
        ->sample_ev;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Simultaneous requests, twice, slave ID 11
        vec("tieA_req",  1,1,0,0,0,0, 2'b00,3'b000,0,0,0);
        vec("tieA_b1",   1,1,1,1,1,0, 2'b01,3'b000,1,0,0);
        vec("tieA_b2",   1,1,1,1,1,0, 2'b01,3'b000,1,0,0);
        vec("tieA_con",  1,1,1,0,0,0, 2'b01,3'b111,1,0,0);
        vec("tieA_drop", 0,0,0,0,0,0, 2'b01,3'b111,1,0,0);
        vec("tieA_rel",  0,0,0,0,0,0, 2'b00,3'b000,1,0,0);
        vec("tieA_idle", 0,0,0,0,0,0, 2'b00,3'b000,0,0,0);
        vec("tieB_req",  1,1,0,0,0,0, 2'b00,3'b000,0,0,0);
        vec("tieB_b1",   1,1,1,1,1,1, WIN2, 3'b000,1,0,0);
        vec("tieB_b2",   1,1,1,1,1,1, WIN2, 3'b000,1,0,0);
        vec("tieB_con",  1,1,1,1,0,0, WIN2, 3'b111,1,0,0);
        vec("tieB_drop", 0,0,0,0,0,0, WIN2, 3'b111,1,0,0);
        vec("tieB_rel",  0,0,0,0,0,0, 2'b00,3'b000,1,0,0);
        vec("tieB_idle", 0,0,0,0,0,0, 2'b00,3'b000,0,0,0);

        // m1 alone, ID 10 -> slave 2
        vec("s2_req",    1,0,0,0,0,0, 2'b00,3'b000,0,0,0);
        vec("s2_b1",     1,0,1,0,1,0, 2'b01,3'b000,1,0,0);
        vec("s2_b2",     1,0,1,0,0,0, 2'b01,3'b000,1,0,0);
        vec("s2_con",    1,0,1,0,0,0, 2'b01,3'b101,1,0,0);
        vec("s2_drop",   0,0,0,0,0,0, 2'b01,3'b101,1,0,0);
        vec("s2_rel",    0,0,0,0,0,0, 2'b00,3'b000,1,0,0);
        vec("s2_idle",   0,0,0,0,0,0, 2'b00,3'b000,0,0,0);

        // m2 alone, ID 00 -> decode error
        vec("de_req",    0,1,0,0,0,0, 2'b00,3'b000,0,0,0);
        vec("de_b1",     0,1,0,1,0,0, 2'b10,3'b000,1,0,0);
        vec("de_b2",     1,1,1,1,1,0, 2'b10,3'b000,1,1,0);
        vec("de_rel",    0,0,0,0,0,0, 2'b00,3'b000,1,0,0);
        vec("de_idle",   0,0,0,0,0,0, 2'b00,3'b000,0,0,0);

        // m1 drops after one ID bit while m2 waits
        vec("hand_req",  1,0,0,0,0,0, 2'b00,3'b000,0,0,0);
        vec("hand_b1",   1,1,1,0,1,0, 2'b01,3'b000,1,0,0);
        vec("hand_drop", 0,1,0,0,0,0, 2'b01,3'b000,1,0,0);
        vec("hand_rel",  0,1,0,0,0,0, 2'b00,3'b000,1,0,0);
        vec("hand_idle", 0,1,0,0,0,0, 2'b00,3'b000,0,0,0);
        vec("hand_m2",   0,1,0,0,0,0, 2'b10,3'b000,1,0,0);
        vec("hand_m2dr", 0,0,0,0,0,0, 2'b10,3'b000,1,0,0);
        vec("hand_rel2", 0,0,0,0,0,0, 2'b00,3'b000,1,0,0);
        vec("hand_end",  0,0,0,0,0,0, 2'b00,3'b000,0,0,0);

        // Timeout (4) to slave 1, with a valid pulse restarting the count
        vec("to_req",    1,0,0,0,0,0, 2'b00,3'b000,0,0,0);
        vec("to_b1",     1,0,1,0,0,0, 2'b01,3'b000,1,0,0);
        vec("to_b2",     1,0,1,0,1,0, 2'b01,3'b000,1,0,0);
        vec("to_i1",     1,0,0,0,0,0, 2'b01,3'b011,1,0,0);
        vec("to_i2",     1,0,0,0,0,0, 2'b01,3'b011,1,0,0);
        vec("to_vld",    1,0,1,0,0,0, 2'b01,3'b011,1,0,0);
        vec("to_j1",     1,0,0,0,0,0, 2'b01,3'b011,1,0,0);
        vec("to_j2",     1,0,0,0,0,0, 2'b01,3'b011,1,0,0);
        vec("to_j3",     1,0,0,0,0,0, 2'b01,3'b011,1,0,0);
        vec("to_j4",     1,0,0,0,0,0, 2'b01,3'b011,1,0,1);
        vec("to_rel",    0,0,0,0,0,0, 2'b00,3'b000,1,0,0);
        vec("to_idle",   0,0,0,0,0,0, 2'b00,3'b000,0,0,0);

        // Request drop coinciding with the 4th idle cycle still reports timeout
        vec("td_req",    1,0,0,0,0,0, 2'b00,3'b000,0,0,0);
        vec("td_b1",     1,0,1,0,0,0, 2'b01,3'b000,1,0,0);
        vec("td_b2",     1,0,1,0,1,0, 2'b01,3'b000,1,0,0);
        vec("td_i1",     1,0,0,0,0,0, 2'b01,3'b011,1,0,0);
        vec("td_i2",     1,0,0,0,0,0, 2'b01,3'b011,1,0,0);
        vec("td_i3",     1,0,0,0,0,0, 2'b01,3'b011,1,0,0);
        vec("td_i4drop", 0,0,0,0,0,0, 2'b01,3'b011,1,0,1);
        vec("td_rel",    0,0,0,0,0,0, 2'b00,3'b000,1,0,0);
        vec("td_idle",   0,0,0,0,0,0, 2'b00,3'b000,0,0,0);

        // Drop on the 2nd ID bit: release without decode
        vec("d2_req",    0,1,0,0,0,0, 2'b00,3'b000,0,0,0);
        vec("d2_b1",     0,1,0,1,0,0, 2'b10,3'b000,1,0,0);
        vec("d2_b2drop", 0,0,0,1,0,0, 2'b10,3'b000,1,0,0);
        vec("d2_rel",    0,0,0,0,0,0, 2'b00,3'b000,1,0,0);
        vec("d2_idle",   0,0,0,0,0,0, 2'b00,3'b000,0,0,0);

        // Asynchronous reset in CONNECT, then a fresh grant
        vec("ar_req",    1,0,0,0,0,0, 2'b00,3'b000,0,0,0);
        vec("ar_b1",     1,0,1,0,1,0, 2'b01,3'b000,1,0,0);
        vec("ar_b2",     1,0,1,0,1,0, 2'b01,3'b000,1,0,0);
        vec("ar_con",    1,0,1,0,0,0, 2'b01,3'b111,1,0,0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        drive_idle();
        exp_q.push_back(8'h00);
        nm_q.push_back("async_rst");
        ->sample_ev;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vec("pr_req",    1,0,0,0,0,0, 2'b00,3'b000,0,0,0);
        vec("pr_grant",  1,0,0,0,0,0, 2'b01,3'b000,1,0,0);
        vec("pr_drop",   0,0,0,0,0,0, 2'b01,3'b000,1,0,0);
        vec("pr_rel",    0,0,0,0,0,0, 2'b00,3'b000,1,0,0);
        vec("pr_idle",   0,0,0,0,0,0, 2'b00,3'b000,0,0,0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
